bram1_arbiter: RTL
==================

BRAM1_ARBITER -- requirements
Module: bram1_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 1, meaning the BRAM address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 1, meaning the BRAM data width.
REQ-003 SHALL have parameter PIPELINED, default 0, meaning the attached BRAM read latency L = 1 + PIPELINED (0 or 1 only).
REQ-004 SHALL have port CLK  in  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port RST  in  1  reset, synchronous and active-high.
REQ-006 SHALL have ports A_REQ_VALID in 1, A_REQ_READY out 1, A_REQ_WE in 1, A_REQ_ADDR in ADDR_WIDTH, A_REQ_DATA in DATA_WIDTH, forming requester A's request channel.
REQ-007 SHALL have ports A_RSP_VALID out 1, A_RSP_READY in 1, A_RSP_DATA out DATA_WIDTH, forming requester A's read-response channel.
REQ-008 SHALL have the identical set B_REQ_* and B_RSP_* for requester B.
REQ-009 SHALL have ports BRAM_EN out 1, BRAM_WE out 1, BRAM_ADDR out ADDR_WIDTH, BRAM_DI out DATA_WIDTH, and BRAM_DO in DATA_WIDTH, all connecting to one single-ported BRAM.

Function
REQ-010 SHALL perform at most one BRAM access per cycle; a request is granted in a cycle where REQ_VALID and REQ_READY are both high.
REQ-011 SHALL treat port X as eligible when X_REQ_VALID=1 and either X_REQ_WE=1, or no read is pending for X.
REQ-012 SHALL define "read pending for X" as a granted X read still in the tag pipeline, or X_RSP_VALID=1.
REQ-013 SHALL grant the sole eligible port if only one is eligible; if both are eligible, SHALL grant the port holding priority.
REQ-014 SHALL hand priority to the other port after every grant, and leave it unchanged in cycles with no grant.
REQ-015 SHALL assert REQ_READY only to the port being granted, combinationally in the same cycle; READY SHALL be 0 to the other port.
REQ-016 SHALL drive the BRAM combinationally from the winner in the grant cycle: BRAM_EN=1, BRAM_WE=X_REQ_WE, BRAM_ADDR=X_REQ_ADDR, BRAM_DI=X_REQ_DATA.
REQ-017 SHALL drive BRAM_EN=0, BRAM_WE=0, BRAM_ADDR=0 and BRAM_DI=0 in any cycle with no grant.
REQ-018 SHALL carry each granted read as a tag (valid, port) through an L-stage shift register; granted writes SHALL produce no tag and no response.
REQ-019 For a read granted in cycle t, SHALL capture BRAM_DO into the owning port's response register on the edge ending cycle t+L, with X_RSP_VALID=1 from cycle t+L+1.
REQ-020 SHALL hold X_RSP_VALID and X_RSP_DATA stable until X_RSP_READY=1, then clear X_RSP_VALID on that edge.
REQ-021 SHALL allow a new X read to be granted no earlier than the cycle after the X response handshake; it SHALL NOT be granted in the handshake cycle itself.
REQ-022 SHALL allow a port to receive back-to-back write grants every cycle while the other port is not eligible.
REQ-023 SHALL leave a port's pending read and held response unaffected by that port's writes; a port may write while its read is pending.
REQ-024 SHALL NOT exceed one outstanding read per port, so response registers never overflow.

Reset
REQ-025 While RST=1, SHALL drive A/B_REQ_READY=0 and BRAM_EN=0, BRAM_WE=0, BRAM_ADDR=0, BRAM_DI=0.
REQ-026 On a clock edge with RST=1, SHALL clear all tag stages, set A/B_RSP_VALID=0 and A/B_RSP_DATA=0, and give priority to A.
REQ-027 Reset mid-operation SHALL silently drop in-flight reads and held responses; no RSP_VALID SHALL appear for them after RST deasserts.

Verification
REQ-028 Reset, then A writes 0x5A to addr 3 in cycle 0 while B is idle -> A_REQ_READY=1, BRAM_EN=1, BRAM_WE=1 in cycle 0; no A_RSP_VALID ever.
REQ-029 PIPELINED=0, A reads addr 3 in cycle 0 with A_RSP_READY=1 -> A_RSP_VALID=1, A_RSP_DATA=0x5A in cycle 2; PIPELINED=1 -> same in cycle 3.
REQ-030 A and B both hold valid writes for 4 cycles after reset -> grants in order A, B, A, B, with exactly one REQ_READY high per cycle.
REQ-031 A reads with A_RSP_READY=0 for 5 cycles while A keeps a read valid -> A_REQ_READY stays 0 and A_RSP_DATA stays stable; B writes are granted meanwhile; the second A read is granted the cycle after A_RSP_READY=1.
REQ-032 RST pulsed in the cycle after a read grant (PIPELINED=1) -> that read never produces a response, and after reset the first contended grant goes to A.

Source files
------------

// File: rtl/bram1_arbiter_if.sv
// Request/response bundle for the two-requester single-port BRAM arbiter.
// slave is the arbiter side; master is the requesters-plus-BRAM side.
interface bram1_arbiter_if #(
    parameter int ADDR_WIDTH = 1,
    parameter int DATA_WIDTH = 1
) ();
    logic                  A_REQ_VALID;
    logic                  A_REQ_READY;
    logic                  A_REQ_WE;
    logic [ADDR_WIDTH-1:0] A_REQ_ADDR;
    logic [DATA_WIDTH-1:0] A_REQ_DATA;
    logic                  A_RSP_VALID;
    logic                  A_RSP_READY;
    logic [DATA_WIDTH-1:0] A_RSP_DATA;

    logic                  B_REQ_VALID;
    logic                  B_REQ_READY;
    logic                  B_REQ_WE;
    logic [ADDR_WIDTH-1:0] B_REQ_ADDR;
    logic [DATA_WIDTH-1:0] B_REQ_DATA;
    logic                  B_RSP_VALID;
    logic                  B_RSP_READY;
    logic [DATA_WIDTH-1:0] B_RSP_DATA;

    logic                  BRAM_EN;
    logic                  BRAM_WE;
    logic [ADDR_WIDTH-1:0] BRAM_ADDR;
    logic [DATA_WIDTH-1:0] BRAM_DI;
    logic [DATA_WIDTH-1:0] BRAM_DO;

    modport slave (
        input  A_REQ_VALID, A_REQ_WE, A_REQ_ADDR, A_REQ_DATA,
        output A_REQ_READY,
        output A_RSP_VALID, A_RSP_DATA,
        input  A_RSP_READY,
        input  B_REQ_VALID, B_REQ_WE, B_REQ_ADDR, B_REQ_DATA,
        output B_REQ_READY,
        output B_RSP_VALID, B_RSP_DATA,
        input  B_RSP_READY,
        output BRAM_EN, BRAM_WE, BRAM_ADDR, BRAM_DI,
        input  BRAM_DO
    );

    modport master (
        output A_REQ_VALID, A_REQ_WE, A_REQ_ADDR, A_REQ_DATA,
        input  A_REQ_READY,
        input  A_RSP_VALID, A_RSP_DATA,
        output A_RSP_READY,
        output B_REQ_VALID, B_REQ_WE, B_REQ_ADDR, B_REQ_DATA,
        input  B_REQ_READY,
        input  B_RSP_VALID, B_RSP_DATA,
        output B_RSP_READY,
        input  BRAM_EN, BRAM_WE, BRAM_ADDR, BRAM_DI,
        output BRAM_DO
    );
endinterface

// File: rtl/bram1_arbiter.sv
// Round-robin arbiter sharing one single-port BRAM between two requesters,
// with at most one outstanding read per requester and held read responses.
module bram1_arbiter #(
    parameter int ADDR_WIDTH = 1,
    parameter int DATA_WIDTH = 1,
    parameter int PIPELINED  = 0
) (
    input logic            CLK,
    input logic            RST,
    bram1_arbiter_if.slave bus
);
    localparam int L = 1 + PIPELINED;

    logic [L-1:0]          tag_v;
    logic [L-1:0]          tag_b;
    logic                  prio_b;
    logic                  a_rsp_valid;
    logic                  b_rsp_valid;
    logic [DATA_WIDTH-1:0] a_rsp_data;
    logic [DATA_WIDTH-1:0] b_rsp_data;

    logic pend_a;
    logic pend_b;
    logic elig_a;
    logic elig_b;
    logic gnt_a;
    logic gnt_b;
    logic rd_gnt;

    logic                  bram_en;
    logic                  bram_we;
    logic [ADDR_WIDTH-1:0] bram_addr;
    logic [DATA_WIDTH-1:0] bram_di;

    // A read is pending while its tag is in flight or its response is held.
    always_comb begin
        pend_a = a_rsp_valid;
        pend_b = b_rsp_valid;
        for (int i = 0; i < L; i++) begin
            pend_a = pend_a | (tag_v[i] & ~tag_b[i]);
            pend_b = pend_b | (tag_v[i] & tag_b[i]);
        end
    end

    assign elig_a = ~RST & bus.A_REQ_VALID & (bus.A_REQ_WE | ~pend_a);
    assign elig_b = ~RST & bus.B_REQ_VALID & (bus.B_REQ_WE | ~pend_b);
    assign gnt_a  = elig_a & (~elig_b | ~prio_b);
    assign gnt_b  = elig_b & (~elig_a | prio_b);
    assign rd_gnt = (gnt_a & ~bus.A_REQ_WE) | (gnt_b & ~bus.B_REQ_WE);

    always_comb begin
        bram_en   = 1'b0;
        bram_we   = 1'b0;
        bram_addr = '0;
        bram_di   = '0;
        unique case (1'b1)
            gnt_a: begin
                bram_en   = 1'b1;
                bram_we   = bus.A_REQ_WE;
                bram_addr = bus.A_REQ_ADDR;
                bram_di   = bus.A_REQ_DATA;
            end
            gnt_b: begin
                bram_en   = 1'b1;
                bram_we   = bus.B_REQ_WE;
                bram_addr = bus.B_REQ_ADDR;
                bram_di   = bus.B_REQ_DATA;
            end
            default: begin
                bram_en = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            tag_v       <= '0;
            tag_b       <= '0;
            prio_b      <= 1'b0;
            a_rsp_valid <= 1'b0;
            b_rsp_valid <= 1'b0;
            a_rsp_data  <= '0;
            b_rsp_data  <= '0;
        end else begin
            tag_v[0] <= rd_gnt;
            tag_b[0] <= gnt_b;
            for (int i = 1; i < L; i++) begin
                tag_v[i] <= tag_v[i-1];
                tag_b[i] <= tag_b[i-1];
            end
            if (gnt_a | gnt_b) begin
                prio_b <= gnt_a;
            end
            // The last tag stage lines up with BRAM_DO for that read.
            if (tag_v[L-1] & ~tag_b[L-1]) begin
                a_rsp_valid <= 1'b1;
                a_rsp_data  <= bus.BRAM_DO;
            end else if (a_rsp_valid & bus.A_RSP_READY) begin
                a_rsp_valid <= 1'b0;
            end
            if (tag_v[L-1] & tag_b[L-1]) begin
                b_rsp_valid <= 1'b1;
                b_rsp_data  <= bus.BRAM_DO;
            end else if (b_rsp_valid & bus.B_RSP_READY) begin
                b_rsp_valid <= 1'b0;
            end
        end
    end

    assign bus.A_REQ_READY = gnt_a;
    assign bus.B_REQ_READY = gnt_b;
    assign bus.A_RSP_VALID = a_rsp_valid;
    assign bus.B_RSP_VALID = b_rsp_valid;
    assign bus.A_RSP_DATA  = a_rsp_data;
    assign bus.B_RSP_DATA  = b_rsp_data;
    assign bus.BRAM_EN     = bram_en;
    assign bus.BRAM_WE     = bram_we;
    assign bus.BRAM_ADDR   = bram_addr;
    assign bus.BRAM_DI     = bram_di;
endmodule
